// File: rtl/fabric_switch_cfg_loader.sv
// Streams a route table into a shadow register, quiesces the switch,
// then swaps the shadow into the live route table in one cycle.
module fabric_switch_cfg_loader #(
  parameter int NUM_INPUTS    = 4,
  parameter int NUM_CONNECTED = 16,
  parameter int WORD_WIDTH    = 32,
  parameter int DRAIN_TIMEOUT = 255,
  parameter logic [NUM_CONNECTED-1:0] RESET_ROUTE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [WORD_WIDTH-1:0]    cfg_data,
  input  logic                     cfg_last,
  input  logic [NUM_INPUTS-1:0]    sw_in_valid,
  output logic                     gate,
  output logic [NUM_CONNECTED-1:0] cfg_route_table,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     error_valid,
  output logic [15:0]              error_code
);

  localparam int NUM_WORDS =
    (NUM_CONNECTED + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int WIDX_W = $clog2(NUM_WORDS + 1);
  localparam int PAD_W  = NUM_WORDS * WORD_WIDTH;
  localparam int CNT_W  =
    (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_TIMEOUT - 1);

  localparam logic [15:0] ERR_SHORT = 16'd4;
  localparam logic [15:0] ERR_LONG  = 16'd5;
  localparam logic [15:0] ERR_DRAIN = 16'd263;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_ERROR
  } state_t;

  state_t                   state;
  logic [WIDX_W-1:0]        widx;
  logic [CNT_W-1:0]         drain_cnt;
  logic [NUM_CONNECTED-1:0] shadow;
  logic [NUM_CONNECTED-1:0] shadow_nxt;
  logic [PAD_W-1:0]         pad;
  logic                     accept;
  logic                     at_last;
  logic                     before_last;
  int                       sel;

  assign cfg_ready = (state == S_IDLE) || (state == S_LOAD);
  assign gate      = (state == S_DRAIN);
  assign cfg_busy  = (state == S_LOAD) || (state == S_DRAIN);
  assign accept    = cfg_valid && cfg_ready;

  assign at_last     = (int'(widx) == NUM_WORDS - 1);
  assign before_last = (int'(widx) <  NUM_WORDS - 1);

  // Bits of the final word beyond NUM_CONNECTED fall off the padded view.
  always_comb begin
    sel = (state == S_IDLE) ? 0 : int'(widx);
    pad = '0;
    pad[NUM_CONNECTED-1:0] = shadow;
    if (sel < NUM_WORDS) begin
      pad[sel*WORD_WIDTH +: WORD_WIDTH] = cfg_data;
    end
    shadow_nxt = pad[NUM_CONNECTED-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      widx            <= '0;
      drain_cnt       <= '0;
      shadow          <= '0;
      cfg_route_table <= RESET_ROUTE;
      cfg_done        <= 1'b0;
      error_valid     <= 1'b0;
      error_code      <= '0;
    end else begin
      cfg_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            shadow <= shadow_nxt;
            if (!cfg_last) begin
              widx  <= WIDX_W'(1);
              state <= S_LOAD;
            end else if (NUM_WORDS == 1) begin
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end else begin
              state <= S_ERROR;
              if (!error_valid) begin
                error_valid <= 1'b1;
                error_code  <= ERR_SHORT;
              end
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            shadow <= shadow_nxt;
            widx   <= widx + WIDX_W'(1);
            if (cfg_last && at_last) begin
              widx      <= '0;
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end else if (cfg_last && before_last) begin
              state <= S_ERROR;
              if (!error_valid) begin
                error_valid <= 1'b1;
                error_code  <= ERR_SHORT;
              end
            end else if (!before_last) begin
              state <= S_ERROR;
              if (!error_valid) begin
                error_valid <= 1'b1;
                error_code  <= ERR_LONG;
              end
            end
          end
        end
        S_DRAIN: begin
          if (sw_in_valid == '0) begin
            cfg_route_table <= shadow;
            cfg_done        <= 1'b1;
            widx            <= '0;
            state           <= S_IDLE;
          end else if (drain_cnt == CNT_MAX) begin
            state <= S_ERROR;
            if (!error_valid) begin
              error_valid <= 1'b1;
              error_code  <= ERR_DRAIN;
            end
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        S_ERROR: begin
          state <= S_ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fabric_switch_cfg_loader.sv
// Bench for fabric_switch_cfg_loader: two-word instance plus a
// single-word instance, table vectors, random loads, reset corners.
module tb_fabric_switch_cfg_loader;

  localparam int NC = 40;
  localparam int TO = 8;
  localparam logic [NC-1:0] RR = 40'h5A_C3A5_0F1E;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [31:0]   cfg_data;
  logic          cfg_last;
  logic [3:0]    sw;
  logic          gate;
  logic [NC-1:0] tab;
  logic          busy;
  logic          done;
  logic          ev;
  logic [15:0]   ec;

  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_data;
  logic          s_last;
  logic [3:0]    s_sw;
  logic          s_gate;
  logic [15:0]   s_tab;
  logic          s_busy;
  logic          s_done;
  logic          s_ev;
  logic [15:0]   s_ec;

  always #5 clk = ~clk;

  fabric_switch_cfg_loader #(
    .NUM_INPUTS(4), .NUM_CONNECTED(NC), .WORD_WIDTH(32),
    .DRAIN_TIMEOUT(TO), .RESET_ROUTE(RR)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last),
    .sw_in_valid(sw), .gate(gate),
    .cfg_route_table(tab), .cfg_busy(busy),
    .cfg_done(done), .error_valid(ev), .error_code(ec)
  );

  fabric_switch_cfg_loader u1 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(s_valid), .cfg_ready(s_ready),
    .cfg_data(s_data), .cfg_last(s_last),
    .sw_in_valid(s_sw), .gate(s_gate),
    .cfg_route_table(s_tab), .cfg_busy(s_busy),
    .cfg_done(s_done), .error_valid(s_ev), .error_code(s_ec)
  );

  typedef struct {
    int nbeats;
    int last_at;
    int hold;
    int code;
  } vec_t;

  int errs = 0;
  int checks = 0;
  logic [NC-1:0] cur_tab;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0; sw = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_sw = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tab", tab, RR);
    chk("rst_ctl", {gate, cfg_ready, busy, done, ev}, 5'b01000);
    chk("rst_code", ec, 0);
    chk("rst_s_tab", s_tab, 0);
    chk("rst_s_ctl", {s_gate, s_ready, s_busy, s_done, s_ev}, 5'b01000);
    cur_tab = RR;
  endtask

  task automatic reject_beat(input int code);
    cfg_valid = 1'b1; cfg_last = 1'b1; cfg_data = $urandom;
    chk("err_ready", cfg_ready, 0);
    @(negedge clk);
    chk("err_sticky", {ev, ec}, {1'b1, code[15:0]});
    chk("err_hold", {gate, cfg_ready, busy, done}, 4'b0000);
    chk("err_tab", tab, cur_tab);
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit rst);
    logic [31:0]   d [2];
    logic [NC-1:0] exp_tab;
    int            end_k;
    bit            commit;
    d[0] = $urandom;
    d[1] = $urandom;
    if (rst) do_reset();
    exp_tab = {d[1][7:0], d[0]};
    for (int b = 0; b < v.nbeats; b++) begin
      cfg_valid = 1'b1;
      cfg_data  = d[b];
      cfg_last  = (b == v.last_at);
      chk("beat_ready", cfg_ready, 1);
      @(negedge clk);
      cfg_valid = 1'b0; cfg_last = 1'b0;
      if ((v.code == 4 || v.code == 5) && b == v.nbeats - 1) begin
        chk("len_err", {ev, ec}, {1'b1, v.code[15:0]});
        chk("len_tab", tab, cur_tab);
        chk("len_ctl", {gate, cfg_ready, busy, done}, 4'b0000);
        reject_beat(v.code);
        return;
      end
      if (b != v.last_at) begin
        chk("mid_ctl", {gate, cfg_ready, busy, done}, 4'b0110);
        chk("mid_tab", tab, cur_tab);
      end
    end
    commit = (v.code == 0);
    end_k  = commit ? v.hold + 1 : TO;
    for (int k = 1; k <= end_k; k++) begin
      chk("drain_ctl", {gate, cfg_ready, busy, done}, 4'b1010);
      chk("drain_tab", tab, cur_tab);
      sw = (k <= v.hold) ? 4'b0010 : 4'b0000;
      @(negedge clk);
    end
    sw = '0;
    if (commit) begin
      chk("commit_ctl", {gate, cfg_ready, busy, done, ev}, 5'b01010);
      chk("commit_tab", tab, exp_tab);
      cur_tab = exp_tab;
    end else begin
      chk("tmo_err", {ev, ec}, {1'b1, 16'd263});
      chk("tmo_tab", tab, cur_tab);
      chk("tmo_ctl", {gate, cfg_ready, busy, done}, 4'b0000);
      reject_beat(263);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    vecs = '{
      '{2, 1, 0, 0},
      '{2, 1, 5, 0},
      '{2, 1, 7, 0},
      '{2, 1, 8, 263},
      '{2, 1, 20, 263},
      '{1, 0, 0, 4},
      '{2, -1, 0, 5}
    };
    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b1);

    // back-to-back loads with random drain holds and gaps
    run_vec('{2, 1, 0, 0}, 1'b1);
    for (int i = 0; i < 25; i++) begin
      vec_t r;
      r = '{2, 1, int'($urandom_range(0, 6)), 0};
      run_vec(r, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        chk("gap_done", done, 0);
        chk("gap_tab", tab, cur_tab);
      end
    end

    // async reset while draining discards the pending table
    cfg_valid = 1'b1; cfg_data = $urandom; cfg_last = 1'b0;
    @(negedge clk);
    cfg_data = $urandom; cfg_last = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_last = 1'b0; sw = 4'b0100;
    @(negedge clk);
    chk("pre_rst_gate", gate, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tab", tab, RR);
    chk("async_ctl", {gate, cfg_ready, busy, done, ev}, 5'b01000);
    chk("async_code", ec, 0);
    @(negedge clk);
    rst_n = 1'b1; sw = '0;
    cur_tab = RR;
    @(negedge clk);
    run_vec('{2, 1, 2, 0}, 1'b0);

    // single-word instance: one beat with last commits two cycles later
    do_reset();
    s_valid = 1'b1; s_data = 32'h0000_8421; s_last = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    chk("sw_drain", {s_gate, s_ready, s_busy}, 3'b101);
    chk("sw_tab_hold", s_tab, 0);
    @(negedge clk);
    chk("sw_commit", {s_gate, s_done, s_ev}, 3'b010);
    chk("sw_tab", s_tab, 16'h8421);
    @(negedge clk);
    chk("sw_done_pulse", {s_gate, s_done, s_ready}, 3'b001);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
